// File: rtl/bist_pkg.sv
// Shared BIST definitions: checkerboard constants and the
// FSM state encoding common to every BIST stage.
package bist_pkg;

   localparam int BIST_AW = 8;
   localparam int BIST_DW = 4;

   localparam logic [BIST_DW-1:0] CHK_EVEN = 4'b0101;
   localparam logic [BIST_DW-1:0] CHK_ODD  = 4'b1010;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } bist_state_e;

   // Only the address LSB and the latched phase pick the nibble.
   function automatic logic [BIST_DW-1:0] chk_exp(
      input logic odd,
      input logic rev
   );
      return (odd ^ rev) ? CHK_ODD : CHK_EVEN;
   endfunction

endpackage

// File: rtl/chk_verify_if.sv
// Read-back checker bus: start/phase controls, SRAM read
// port and the result signals seen by the BIST controller.
interface chk_verify_if
   import bist_pkg::*;
#(
   parameter int AW = BIST_AW,
   parameter int DW = BIST_DW
);

   logic          en_in;
   logic          rev_in;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] addr_out;
   logic          r_en_out;
   logic          busy;
   logic          done;
   logic          pass;
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_data;
   logic [AW:0]   err_count;

   modport master (
      output en_in,
      output rev_in,
      output rd_data,
      input  addr_out,
      input  r_en_out,
      input  busy,
      input  done,
      input  pass,
      input  fail_addr,
      input  fail_data,
      input  err_count
   );

   modport slave (
      input  en_in,
      input  rev_in,
      input  rd_data,
      output addr_out,
      output r_en_out,
      output busy,
      output done,
      output pass,
      output fail_addr,
      output fail_data,
      output err_count
   );

endinterface

// File: rtl/chk_exp_pipe.sv
// Delay line carrying {valid, addr, expected} so each compare
// lines up with the SRAM data returned LAT cycles later.
module chk_exp_pipe
   import bist_pkg::*;
#(
   parameter int AW  = BIST_AW,
   parameter int DW  = BIST_DW,
   parameter int LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          v_in,
   input  logic [AW-1:0] a_in,
   input  logic [DW-1:0] e_in,
   output logic          v_out,
   output logic [AW-1:0] a_out,
   output logic [DW-1:0] e_out
);

   logic          v_q [LAT];
   logic          v_d [LAT];
   logic [AW-1:0] a_q [LAT];
   logic [AW-1:0] a_d [LAT];
   logic [DW-1:0] e_q [LAT];
   logic [DW-1:0] e_d [LAT];

   always_comb begin
      v_d[0] = v_in;
      a_d[0] = a_in;
      e_d[0] = e_in;
      for (int i = 1; i < LAT; i++) begin
         v_d[i] = v_q[i-1];
         a_d[i] = a_q[i-1];
         e_d[i] = e_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            v_q[i] <= 1'b0;
            a_q[i] <= '0;
            e_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < LAT; i++) begin
            v_q[i] <= v_d[i];
            a_q[i] <= a_d[i];
            e_q[i] <= e_d[i];
         end
      end
   end

   assign v_out = v_q[LAT-1];
   assign a_out = a_q[LAT-1];
   assign e_out = e_q[LAT-1];

endmodule

// File: rtl/chk_verify.sv
// Checkerboard read-back checker: sweeps the SRAM, compares
// each nibble and reports pass, first failure and error count.
module chk_verify
   import bist_pkg::*;
#(
   parameter int AW     = BIST_AW,
   parameter int DW     = BIST_DW,
   parameter int RD_LAT = 1
) (
   input logic         clk,
   input logic         rst_n,
   chk_verify_if.slave bus
);

   localparam logic [AW-1:0] LAST = '1;
   localparam logic [AW:0]   SAT  = {1'b1, {AW{1'b0}}};
   localparam logic [2:0]    DRN_END = 3'(RD_LAT - 1);

   bist_state_e   state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [2:0]    drn_q, drn_d;
   logic          rev_q, rev_d;
   logic          first_q, first_d;
   logic [AW-1:0] fa_q, fa_d;
   logic [DW-1:0] fd_q, fd_d;
   logic [AW:0]   err_q, err_d;
   logic          pass_q, pass_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;

   logic          p_v;
   logic [AW-1:0] p_a;
   logic [DW-1:0] p_e;
   logic          rd_on;
   logic          mism;

   assign rd_on = (state_q == READ);

   chk_exp_pipe #(
      .AW  (AW),
      .DW  (DW),
      .LAT (RD_LAT)
   ) u_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .v_in  (rd_on),
      .a_in  (cnt_q),
      .e_in  (DW'(chk_exp(cnt_q[0], rev_q))),
      .v_out (p_v),
      .a_out (p_a),
      .e_out (p_e)
   );

   assign mism = p_v & (bus.rd_data != p_e);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drn_d   = drn_q;
      rev_d   = rev_q;
      first_d = first_q;
      fa_d    = fa_q;
      fd_d    = fd_q;
      err_d   = err_q;
      pass_d  = pass_q;
      done_d  = 1'b0;
      busy_d  = busy_q;

      if (mism) begin
         if (err_q != SAT) begin
            err_d = err_q + 1'b1;
         end
         if (!first_q) begin
            first_d = 1'b1;
            fa_d    = p_a;
            fd_d    = bus.rd_data;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (bus.en_in) begin
               state_d = READ;
               rev_d   = bus.rev_in;
               cnt_d   = '0;
               err_d   = '0;
               fa_d    = '0;
               fd_d    = '0;
               first_d = 1'b0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         READ: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = DRAIN;
               drn_d   = '0;
            end
         end
         DRAIN: begin
            // err_d already holds the final compare of the sweep
            if (drn_q == DRN_END) begin
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               pass_d  = (err_d == '0);
            end else begin
               drn_d = drn_q + 3'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         drn_q   <= '0;
         rev_q   <= 1'b0;
         first_q <= 1'b0;
         fa_q    <= '0;
         fd_q    <= '0;
         err_q   <= '0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drn_q   <= drn_d;
         rev_q   <= rev_d;
         first_q <= first_d;
         fa_q    <= fa_d;
         fd_q    <= fd_d;
         err_q   <= err_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.addr_out  = cnt_q;
   assign bus.r_en_out  = rd_on;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.fail_addr = fa_q;
   assign bus.fail_data = fd_q;
   assign bus.err_count = err_q;

endmodule

// File: tb/tb_chk_verify.sv
// Scoreboard bench for chk_verify: two instances (RD_LAT 1 and 3)
// share stimulus and memory contents, each with its own monitor.
module tb_chk_verify;

   localparam int AW = 8;
   localparam int DW = 4;

   typedef struct {
      bit pass;
      int errs;
      int fa;
      int fd;
      int dcyc;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          rev = 1'b0;
   logic [DW-1:0] mem [256];
   int            cyc = 0;
   int            checks = 0;
   int            failures = 0;
   res_t          exp_q [2][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(int g);
      return (g == 0) ? 1 : 3;
   endfunction

   task automatic chk(string nm, longint act, longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: walk the whole array against the checkerboard rule.
   function automatic res_t model(int s, int lat, bit r);
      res_t          m;
      logic [DW-1:0] x;
      m.errs = 0;
      m.fa   = 0;
      m.fd   = 0;
      for (int a = 0; a < 256; a++) begin
         x = (((a % 2) == 1) != r) ? 4'hA : 4'h5;
         if (mem[a] != x) begin
            if (m.errs == 0) begin
               m.fa = a;
               m.fd = int'(mem[a]);
            end
            m.errs++;
         end
      end
      if (m.errs > 256) m.errs = 256;
      m.pass = (m.errs == 0);
      m.dcyc = s + 257 + lat;
      return m;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : 3;

      chk_verify_if #(.AW(AW), .DW(DW)) bus ();
      logic [DW-1:0] dq [LAT];
      int            nrd = 0;

      chk_verify #(
         .AW     (AW),
         .DW     (DW),
         .RD_LAT (LAT)
      ) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );

      assign bus.en_in   = en;
      assign bus.rev_in  = rev;
      assign bus.rd_data = dq[LAT-1];

      always @(posedge clk) begin
         dq[0] <= mem[bus.addr_out];
         for (int i = 1; i < LAT; i++) dq[i] <= dq[i-1];
      end

      always @(negedge clk) begin : mon
         res_t e;
         if (!rst_n) begin
            chk($sformatf("rst_zero_l%0d", LAT),
                {bus.addr_out, bus.r_en_out, bus.busy,
                 bus.done, bus.pass, bus.fail_addr,
                 bus.fail_data, bus.err_count}, 0);
            exp_q[g].delete();
            nrd = 0;
         end else begin
            if (bus.r_en_out) begin
               chk($sformatf("addr_l%0d", LAT), bus.addr_out, nrd);
               chk($sformatf("busy_l%0d", LAT), bus.busy, 1);
               nrd++;
            end
            if (bus.done) begin
               if (exp_q[g].size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL done_l%0d: got unexpected done at cycle %0d expected none",
                           LAT, cyc);
               end else begin
                  e = exp_q[g].pop_front();
                  chk($sformatf("pass_l%0d", LAT), bus.pass, e.pass);
                  chk($sformatf("errs_l%0d", LAT), bus.err_count, e.errs);
                  chk($sformatf("faddr_l%0d", LAT), bus.fail_addr, e.fa);
                  chk($sformatf("fdata_l%0d", LAT), bus.fail_data, e.fd);
                  chk($sformatf("dcyc_l%0d", LAT), cyc, e.dcyc);
                  chk($sformatf("busy_done_l%0d", LAT), bus.busy, 0);
               end
               chk($sformatf("nreads_l%0d", LAT), nrd, 256);
               nrd = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic fill();
      for (int a = 0; a < 256; a++) mem[a] = (a % 2 == 1) ? 4'hA : 4'h5;
   endtask

   task automatic start(bit r);
      int s;
      tick();
      en  = 1'b1;
      rev = r;
      s   = cyc;
      for (int g = 0; g < 2; g++) exp_q[g].push_back(model(s, lat_of(g), r));
      tick();
      en  = 1'b0;
      rev = 1'($urandom);
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (i < 700 && (exp_q[0].size() != 0 || exp_q[1].size() != 0)) begin
         tick();
         i++;
      end
      if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
         checks++;
         failures++;
         $display("FAIL timeout: got pending=%0d/%0d expected 0/0",
                  exp_q[0].size(), exp_q[1].size());
         exp_q[0].delete();
         exp_q[1].delete();
      end
      repeat (4) tick();
   endtask

   initial begin
      int s;
      fill();
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // clean rev=0 memory
      start(1'b0);
      wait_idle();

      // stuck nibble at 0x37
      mem[8'h37] = 4'hF;
      start(1'b0);
      wait_idle();

      // phase mismatch: every address fails
      fill();
      start(1'b1);
      wait_idle();

      // mismatches at both ends of the array
      mem[0]   = 4'h0;
      mem[255] = 4'h0;
      start(1'b0);
      wait_idle();

      // en pulse mid-sweep must be ignored
      fill();
      start(1'b0);
      repeat (99) tick();
      en = 1'b1;
      tick();
      en = 1'b0;
      wait_idle();

      // reset mid-sweep, then a fresh clean sweep
      start(1'b0);
      repeat (119) tick();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      start(1'b0);
      wait_idle();

      // en held high: LAT=1 restarts once, LAT=3 does not
      tick();
      en  = 1'b1;
      rev = 1'b0;
      s   = cyc;
      exp_q[0].push_back(model(s, 1, 1'b0));
      exp_q[0].push_back(model(s + 259, 1, 1'b0));
      exp_q[1].push_back(model(s, 3, 1'b0));
      repeat (261) tick();
      en = 1'b0;
      wait_idle();

      // randomized faults and phase
      for (int k = 0; k < 5; k++) begin
         fill();
         for (int f = 0; f < int'($urandom_range(0, 6)); f++) begin
            mem[$urandom_range(0, 255)] = 4'($urandom);
         end
         start(1'($urandom));
         wait_idle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
